mem_access_responder: RTL
=========================

// Module: mem_access_responder
// PURPOSE
//  Memory-side responder for the 3-stage core's EX-stage data access (mem_en, size_sel, addr, wdata).
//  Decodes addr[31:28] to DMEM / IMEM / BIOS / MMIO and produces byte write masks with lane-aligned write data.
//  Returns the registered read word in the MEM/WB stage. Load byte/half extraction by ld_sel stays downstream.
//  Owns the MMIO registers: UART tx/rx handshakes, cycle counter, retired-instruction counter.
// PARAMETERS
//  DMEM_AW   14  DMEM word-address width
//  IMEM_AW   14  IMEM word-address width
//  BIOS_AW   12  BIOS word-address width
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous, active-high reset
//  mem_en      in   1   EX-stage access valid (load or store)
//  size_sel    in   2   0=SB 1=SH 2=SW 3=load (no write)
//  addr        in   32  byte address from ALU
//  wdata       in   32  store data, unaligned (rs2)
//  inst_retire in   1   one instruction retired this cycle
//  dmem_addr   out  DMEM_AW  addr[DMEM_AW+1:2]
//  dmem_we     out  4   DMEM byte write enables
//  dmem_din    out  32  lane-aligned write data (shared by DMEM/IMEM)
//  dmem_dout   in   32  DMEM sync read data, valid 1 cycle after address
//  imem_addr   out  IMEM_AW  IMEM write word address
//  imem_we     out  4   IMEM byte write enables (write-only region)
//  bios_addr   out  BIOS_AW  BIOS data-port word address
//  bios_dout   in   32  BIOS sync read data
//  tx_data     out  8   UART tx byte
//  tx_valid    out  1   tx byte pending
//  tx_ready    in   1   UART accepts tx_data when tx_valid & tx_ready
//  rx_data     in   8   UART rx byte
//  rx_valid    in   1   rx byte available
//  rx_ready    out  1   pop rx byte (comb.)
//  rdata       out  32  MEM/WB read word
// BEHAVIOUR
//  Region map (addr[31:28]): 0001 DMEM rd/wr; 0010 IMEM wr-only; 0100 BIOS rd-only; 1000 MMIO; other = no effect, reads 0.
//  IMEM region 0011 = DMEM+IMEM write both; reads return DMEM.
//  Store = mem_en & size_sel!=3. Mask: SB 4'b0001<<addr[1:0]; SH addr[0]?0000:(addr[1]?1100:0011); SW addr[1:0]==0?1111:0000.
//  Misaligned SH/SW -> mask 0, no MMIO side effect. din: SB byte x4, SH half x2, SW as-is.
//  Write enables are combinational in the EX cycle, gated by mem_en; all 0 when mem_en=0 or in reset.
//  Read: 1-cycle latency. At posedge, register rd_src (DMEM/BIOS/MMIO/ZERO) and the MMIO read value.
//  rdata then muxes dmem_dout / bios_dout / mmio_q / 0.
//  mem_en=0 -> rd_src=ZERO next cycle.
//  MMIO map:
//   0x80000000 R: {30'b0, rx_valid, ~tx_valid}
//   0x80000004 R: {24'b0, rx_data}; rx_ready=1 this cycle iff load & rx_valid. Read with rx_valid=0 returns 0, no pop.
//   0x80000008 W: if tx_valid=0 latch wdata[7:0], set tx_valid next cycle; write while tx_valid=1 is dropped.
//   0x80000010 R: cycle_cnt     0x80000014 R: inst_cnt     0x80000018 W: clear both counters
//  tx_valid clears on the cycle after tx_valid & tx_ready. Handshake and a new write in the same cycle: the write is dropped (tx_valid still 1 that cycle).
//  cycle_cnt +1 every cycle; inst_cnt +1 when inst_retire; both wrap at 2^32.
//  Counter clear at an edge wins over increment (both =0 after). A same-cycle counter read returns the pre-clear value.
//  Reset: tx_valid=0, tx_data=0, counters=0, rd_src=ZERO (rdata=0), mmio_q=0.
//  Reset mid-handshake drops the pending tx byte. rx_ready and all we are 0 while rst=1.
// STRUCTURE
//  Shared package (mem_map_pkg): region codes, MMIO offsets, size_sel encodings, rd_src enum.
//  The controller uses the same size_sel constants.
//  Sub-module store_mask_gen (comb.: size_sel, addr[1:0], wdata -> we[3:0], din). The rest is in this module.
// TESTING
//  SB 0xAB to 0x10000003 -> dmem_we=1000, dmem_din=0xABABABAB; imem_we=0.
//  SH to 0x30000002 data 0x1234 -> dmem_we=imem_we=1100, din=0x12341234.
//  SH to 0x10000001 -> all we=0.
//  Load 0x40000010 -> bios_addr=4; next cycle rdata=bios_dout. Load 0x50000000 -> rdata=0 next cycle.
//  Store 0x41 to 0x80000008 with tx_ready=0 for 3 cycles, then 1 -> tx_valid high 4 cycles, tx_data=0x41, status bit0=0 meanwhile.
//  A second write while pending is ignored.
//  rx_valid=1, rx_data=0x5A, load 0x80000004 -> rx_ready 1 for exactly 1 cycle; rdata=0x5A next cycle.
//  Load with rx_valid=0 -> rx_ready=0, rdata=0.
//  Run 10 cycles with inst_retire on 6 of them, read 0x80000010/14 -> exact counts.
//  Store to 0x80000018 -> both read 0-based next.
//  Assert rst mid-tx -> tx_valid=0 next cycle.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared address-map, access-size and read-source definitions for the core's
// data-side memory responder and the controller that drives it.
package mem_map_pkg;

   localparam logic [3:0] REG_DMEM = 4'b0001;
   localparam logic [3:0] REG_IMEM = 4'b0010;
   localparam logic [3:0] REG_BOTH = 4'b0011;
   localparam logic [3:0] REG_BIOS = 4'b0100;
   localparam logic [3:0] REG_MMIO = 4'b1000;

   localparam logic [1:0] SIZE_SB = 2'd0;
   localparam logic [1:0] SIZE_SH = 2'd1;
   localparam logic [1:0] SIZE_SW = 2'd2;
   localparam logic [1:0] SIZE_LD = 2'd3;

   localparam logic [31:0] MMIO_STATUS = 32'h8000_0000;
   localparam logic [31:0] MMIO_RX     = 32'h8000_0004;
   localparam logic [31:0] MMIO_TX     = 32'h8000_0008;
   localparam logic [31:0] MMIO_CYCLE  = 32'h8000_0010;
   localparam logic [31:0] MMIO_INST   = 32'h8000_0014;
   localparam logic [31:0] MMIO_CLR    = 32'h8000_0018;

   typedef enum logic [1:0] {
      RD_ZERO = 2'd0,
      RD_DMEM = 2'd1,
      RD_BIOS = 2'd2,
      RD_MMIO = 2'd3
   } rd_src_e;

   // IMEM is write-only, so the DMEM+IMEM alias reads back from DMEM.
   function automatic rd_src_e region_rd_src(input logic [3:0] region);
      case (region)
         REG_DMEM, REG_BOTH: return RD_DMEM;
         REG_BIOS:           return RD_BIOS;
         REG_MMIO:           return RD_MMIO;
         default:            return RD_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/store_mask_gen.sv
// Byte write-enable and lane-replicated store data for SB/SH/SW accesses.
// Misaligned halfword/word stores produce an all-zero mask.
module store_mask_gen
   import mem_map_pkg::*;
(
   input  logic [1:0]  size_sel,
   input  logic [1:0]  byte_off,
   input  logic [31:0] wdata,
   output logic [3:0]  we,
   output logic [31:0] din
);

   always_comb begin
      we  = 4'b0000;
      din = wdata;
      case (size_sel)
         SIZE_SB: begin
            we  = 4'b0001 << byte_off;
            din = {4{wdata[7:0]}};
         end
         SIZE_SH: begin
            we  = byte_off[0] ? 4'b0000 : (byte_off[1] ? 4'b1100 : 4'b0011);
            din = {2{wdata[15:0]}};
         end
         SIZE_SW: begin
            we  = (byte_off == 2'b00) ? 4'b1111 : 4'b0000;
            din = wdata;
         end
         default: begin
            we  = 4'b0000;
            din = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_responder.sv
// Data-side memory responder: region decode, store masks, registered read-source
// select for MEM/WB, and the MMIO block (UART handshakes and event counters).
module mem_access_responder
   import mem_map_pkg::*;
#(
   parameter int DMEM_AW = 14,
   parameter int IMEM_AW = 14,
   parameter int BIOS_AW = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_en,
   input  logic [1:0]         size_sel,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   input  logic               inst_retire,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [3:0]         dmem_we,
   output logic [31:0]        dmem_din,
   input  logic [31:0]        dmem_dout,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [3:0]         imem_we,
   output logic [BIOS_AW-1:0] bios_addr,
   input  logic [31:0]        bios_dout,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic [31:0]        rdata
);

   logic [3:0]  region;
   logic        is_load;
   logic        is_store;
   logic [3:0]  mask;
   logic        wr_ok;
   logic        tx_wr;
   logic        cnt_clr;
   logic [31:0] cycle_cnt;
   logic [31:0] inst_cnt;
   logic [31:0] mmio_rd;
   rd_src_e     rd_src_nxt;
   rd_src_e     rd_src_p1;
   logic [31:0] mmio_q_p1;

   assign region   = addr[31:28];
   assign is_load  = mem_en & (size_sel == SIZE_LD) & ~rst;
   assign is_store = mem_en & (size_sel != SIZE_LD) & ~rst;

   store_mask_gen u_store_mask_gen (
      .size_sel (size_sel),
      .byte_off (addr[1:0]),
      .wdata    (wdata),
      .we       (mask),
      .din      (dmem_din)
   );

   // A zero mask marks a misaligned store: it must not touch memory or MMIO state.
   assign wr_ok   = is_store & (|mask);
   assign dmem_we = (wr_ok && (region == REG_DMEM || region == REG_BOTH)) ? mask : 4'b0000;
   assign imem_we = (wr_ok && (region == REG_IMEM || region == REG_BOTH)) ? mask : 4'b0000;

   assign dmem_addr = addr[DMEM_AW+1:2];
   assign imem_addr = addr[IMEM_AW+1:2];
   assign bios_addr = addr[BIOS_AW+1:2];

   assign tx_wr    = wr_ok & (addr == MMIO_TX) & ~tx_valid;
   assign cnt_clr  = wr_ok & (addr == MMIO_CLR);
   assign rx_ready = is_load & (addr == MMIO_RX) & rx_valid;

   always_comb begin
      mmio_rd    = 32'h0;
      rd_src_nxt = RD_ZERO;
      if (is_load) begin
         rd_src_nxt = region_rd_src(region);
         case (addr)
            MMIO_STATUS: mmio_rd = {30'b0, rx_valid, ~tx_valid};
            MMIO_RX:     mmio_rd = rx_valid ? {24'b0, rx_data} : 32'h0;
            MMIO_CYCLE:  mmio_rd = cycle_cnt;
            MMIO_INST:   mmio_rd = inst_cnt;
            default:     mmio_rd = 32'h0;
         endcase
      end
   end

   // EX -> MEM/WB boundary: read source and MMIO read value
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_src_p1 <= RD_ZERO;
         mmio_q_p1 <= 32'h0;
      end else begin
         rd_src_p1 <= rd_src_nxt;
         mmio_q_p1 <= mmio_rd;
      end
   end

   always_comb begin
      case (rd_src_p1)
         RD_DMEM: rdata = dmem_dout;
         RD_BIOS: rdata = bios_dout;
         RD_MMIO: rdata = mmio_q_p1;
         default: rdata = 32'h0;
      endcase
   end

   // Handshake takes priority; a write arriving while a byte is pending is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else if (tx_valid && tx_ready) begin
         tx_valid <= 1'b0;
      end else if (tx_wr) begin
         tx_valid <= 1'b1;
         tx_data  <= wdata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cycle_cnt <= 32'h0;
         inst_cnt  <= 32'h0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         inst_cnt  <= inst_cnt + {31'b0, inst_retire};
      end
   end

endmodule
